imem_loader: RTL and testbench

- Boot-time writer for the core's 8-bit-addressed instruction memory. The core reads this memory.
- Accepts a framed byte stream on a valid/ready interface and packs bytes little-endian into 32-bit words.
- Writes each word to consecutive word addresses starting at the reset PC, then verifies a checksum.
- Holds the core in reset with pc_en low until the load succeeds. After success it releases the core and drives pc_en.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_word_packer.sv | 37 +++
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: memory map and FSM encodings.
package imem_loader_pkg;

  localparam logic [7:0] RESET_PC = 8'h20;
  localparam logic [7:0] HALT_PC  = 8'hF0;

  // Largest image that still ends below the halt address.
  localparam int unsigned LOADER_MAX_WORDS = 32'((HALT_PC - RESET_PC) >> 2);

  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the cycle after lane 3.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] lanes;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      lanes      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    lanes[7:0]   <= byte_data;
          2'd1:    lanes[15:8]  <= byte_data;
          2'd2:    lanes[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, lanes};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a LEN/DATA/CSUM byte frame, writes words to instruction memory,
// and releases the core from reset only after the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = RESET_PC,
  parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        run_hold,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        pc_en,
  output logic        busy,
  output logic        done,
  output logic        load_err,
  output logic [5:0]  words_loaded
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [5:0]         len_q;
  logic [7:0]         sum;
  logic [1:0]         byte_idx;
  logic               accept, data_acc, last_lane, len_ok;

  assign accept    = in_valid && in_ready;
  assign data_acc  = accept && (state == ST_DATA);
  assign last_lane = data_acc && (byte_idx == 2'd3);
  assign len_ok    = (in_data != 8'd0) && (32'(in_data) <= MAX_WORDS);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (data_acc),
    .byte_data  (in_data),
    .byte_idx   (byte_idx),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = len_ok ? ST_DATA : ST_ERR;
      ST_DATA: if (last_lane && (words_loaded + 6'd1 == len_q)) state_nxt = ST_CSUM;
      ST_CSUM: if (accept) state_nxt = (in_data == sum) ? ST_RUN : ST_ERR;
      ST_RUN:  state_nxt = ST_RUN;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  // Checksum, word count and write address; the address uses the pre-increment count.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= 6'd0;
      sum          <= 8'd0;
      words_loaded <= 6'd0;
      imem_addr    <= BASE_ADDR;
    end else begin
      if ((state == ST_IDLE) && accept && len_ok) begin
        len_q        <= 6'(in_data);
        sum          <= 8'd0;
        words_loaded <= 6'd0;
      end
      if (data_acc) sum <= sum + in_data;
      if (last_lane) begin
        imem_addr    <= BASE_ADDR + {words_loaded, 2'b00};
        words_loaded <= words_loaded + 6'd1;
      end
    end
  end

  // Status and core control follow the next state so they settle with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
      core_rst <= 1'b1;
      pc_en    <= 1'b0;
    end else begin
      in_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
      busy     <= (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
      done     <= (state_nxt == ST_RUN);
      load_err <= (state_nxt == ST_ERR);
      core_rst <= (state_nxt != ST_RUN);
      pc_en    <= (state_nxt == ST_RUN) && !run_hold;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus full-size image sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        run_hold = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst, pc_en, busy, done, load_err;
  logic [5:0]  words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .run_hold(run_hold), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .pc_en(pc_en), .busy(busy), .done(done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r, v, h;
    logic [7:0]  d;
    bit          we, bc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          crst, pc, busy, done, err, rdy;
    logic [5:0]  wl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit v, logic [7:0] d, bit h, bit we, logic [7:0] a,
                              logic [31:0] wd, bit bc, bit crst, bit pc, bit bsy, bit dn,
                              bit er, bit rdy, logic [5:0] wl);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.h = h; x.we = we; x.addr = a; x.wdata = wd; x.bc = bc;
    x.crst = crst; x.pc = pc; x.busy = bsy; x.done = dn; x.err = er; x.rdy = rdy; x.wl = wl;
    return x;
  endfunction

  function automatic vec_t rs();
    return mk(1, 0, 8'h00, 0, 0, 8'h20, 32'h0, 1, 1, 0, 0, 0, 0, 1, 6'd0);
  endfunction
  function automatic vec_t dat(logic [7:0] d, logic [5:0] wl);
    return mk(0, 1, d, 0, 0, 8'h00, 32'h0, 0, 1, 0, 1, 0, 0, 1, wl);
  endfunction
  function automatic vec_t wr(logic [7:0] d, logic [7:0] a, logic [31:0] wd, logic [5:0] wl);
    return mk(0, 1, d, 0, 1, a, wd, 1, 1, 0, 1, 0, 0, 1, wl);
  endfunction
  function automatic vec_t err(bit v, logic [7:0] d, bit h, logic [5:0] wl);
    return mk(0, v, d, h, 0, 8'h00, 32'h0, 0, 1, 0, 0, 0, 1, 0, wl);
  endfunction
  function automatic vec_t run(bit h, bit v, logic [7:0] d, bit pc);
    return mk(0, v, d, h, 0, 8'h00, 32'h0, 0, 0, pc, 0, 1, 0, 0, 6'd2);
  endfunction

  task automatic push_two_words();
    vecs.push_back(dat(8'h02, 0));
    vecs.push_back(dat(8'h13, 0));
    vecs.push_back(dat(8'h00, 0));
    vecs.push_back(dat(8'h00, 0));
    vecs.push_back(wr(8'h00, 8'h20, 32'h00000013, 1));
    vecs.push_back(dat(8'h93, 1));
    vecs.push_back(dat(8'h00, 1));
    vecs.push_back(dat(8'h10, 1));
    vecs.push_back(wr(8'h00, 8'h24, 32'h00100093, 2));
  endtask

  task automatic do_rst();
    rst = 1'b1; in_valid = 1'b0; run_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Full 52-word image with correct checksum; optionally with random in_valid gaps.
  task automatic load52(input bit gaps);
    logic [7:0] pl[208];
    logic [7:0] s;
    int         w, tries;
    bit         acc, aborted;
    s = 8'h00; w = 0; aborted = 0;
    for (int k = 0; k < 208; k++) begin
      pl[k] = 8'($urandom);
      s = s + pl[k];
    end
    in_valid = 1'b1; in_data = 8'd52;
    @(posedge clk); #1;
    chk("l52.busy_after_len", 32'(busy), 32'd1);
    for (int k = 0; k < 208 && !aborted; k++) begin
      tries = 0;
      acc = 1'b0;
      while (!acc && !aborted) begin
        in_valid = (gaps && tries < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = pl[k];
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        chk("l52.we", 32'(imem_we), 32'(acc && (k % 4 == 3)));
        if (acc && (k % 4 == 3)) begin
          chk("l52.addr", 32'(imem_addr), 32'(8'h20 + 8'(4 * w)));
          chk("l52.wdata", imem_wdata, {pl[k], pl[k-1], pl[k-2], pl[k-3]});
          w++;
        end
        tries++;
        if (!acc && tries > 20) begin
          chk("l52.ready_timeout", 32'(in_ready), 32'd1);
          aborted = 1;
        end
      end
    end
    chk("l52.write_count", 32'(w), 32'd52);
    in_valid = 1'b1; in_data = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("l52.done", 32'(done), 32'd1);
    chk("l52.pc_en", 32'(pc_en), 32'd1);
    chk("l52.core_rst", 32'(core_rst), 32'd0);
    chk("l52.words", 32'(words_loaded), 32'd52);
    chk("l52.err", 32'(load_err), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Good two-word frame, then run_hold pulse and an ignored byte in RUN.
    vecs.push_back(rs());
    push_two_words();
    vecs.push_back(run(0, 1, 8'hB6, 1));
    vecs.push_back(run(1, 0, 8'h00, 0));
    vecs.push_back(run(1, 0, 8'h00, 0));
    vecs.push_back(run(1, 0, 8'h00, 0));
    vecs.push_back(run(0, 0, 8'h00, 1));
    vecs.push_back(run(0, 1, 8'h55, 1));
    // Same frame with a bad checksum: sticky error, run_hold ignored.
    vecs.push_back(rs());
    push_two_words();
    vecs.push_back(err(1, 8'hB7, 0, 2));
    vecs.push_back(err(1, 8'h02, 0, 2));
    vecs.push_back(err(0, 8'h00, 1, 2));
    // LEN boundaries.
    vecs.push_back(rs());
    vecs.push_back(err(1, 8'h00, 0, 0));
    vecs.push_back(err(1, 8'h13, 0, 0));
    vecs.push_back(rs());
    vecs.push_back(err(1, 8'h35, 0, 0));
    vecs.push_back(err(1, 8'h01, 0, 0));
    vecs.push_back(rs());
    vecs.push_back(dat(8'h34, 0));
    // Reset after six data bytes: only the first word was written.
    vecs.push_back(rs());
    vecs.push_back(dat(8'h02, 0));
    vecs.push_back(dat(8'h13, 0));
    vecs.push_back(dat(8'h00, 0));
    vecs.push_back(dat(8'h00, 0));
    vecs.push_back(wr(8'h00, 8'h20, 32'h00000013, 1));
    vecs.push_back(dat(8'h93, 1));
    vecs.push_back(dat(8'h00, 1));
    vecs.push_back(rs());
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h20, 32'h0, 1, 1, 0, 0, 0, 0, 1, 6'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; in_valid = vecs[i].v; in_data = vecs[i].d; run_hold = vecs[i].h;
      @(posedge clk); #1;
      chk($sformatf("row%0d.we", i), 32'(imem_we), 32'(vecs[i].we));
      if (vecs[i].bc) begin
        chk($sformatf("row%0d.addr", i), 32'(imem_addr), 32'(vecs[i].addr));
        chk($sformatf("row%0d.wdata", i), imem_wdata, vecs[i].wdata);
      end
      chk($sformatf("row%0d.core_rst", i), 32'(core_rst), 32'(vecs[i].crst));
      chk($sformatf("row%0d.pc_en", i), 32'(pc_en), 32'(vecs[i].pc));
      chk($sformatf("row%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d.done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("row%0d.load_err", i), 32'(load_err), 32'(vecs[i].err));
      chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d.words", i), 32'(words_loaded), 32'(vecs[i].wl));
    end

    do_rst();
    load52(1'b0);
    do_rst();
    load52(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
